// File: rtl/solar_rat_io_pkg.sv
// Shared RAT I/O-bus port map for the SolarRAT peripherals, plus the servo
// FSM state type and the servo status-byte layout.
package solar_rat_io_pkg;

  localparam logic [7:0] SWITCHES_ID   = 8'hFF;
  localparam logic [7:0] LIGHT_ID      = 8'h21;
  localparam logic [7:0] LEDS_ID       = 8'h40;
  localparam logic [7:0] SEG_ID        = 8'h81;
  localparam logic [7:0] SERVO_POS_ID  = 8'h22;
  localparam logic [7:0] SERVO_STAT_ID = 8'h23;
  localparam logic [7:0] SERVO_CTRL_ID = 8'h24;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} servo_state_t;

  function automatic logic [7:0] servo_stat(logic pend, logic irq_en, logic en);
    return {5'b0, pend, irq_en, en};
  endfunction

endpackage

// File: rtl/servo_pwm_port_if.sv
// MCU I/O-bus signals as seen by one RAT peripheral.
interface servo_pwm_port_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;

  modport master (output PORT_ID, OUT_PORT, IO_STRB, input IN_DATA);
  modport slave  (input PORT_ID, OUT_PORT, IO_STRB, output IN_DATA);
endinterface

// File: rtl/rat_port_wr_decode.sv
// IO_STRB rising-edge detect plus port-ID match; one single-cycle write strobe
// per configured ID, however long the MCU holds IO_STRB.
module rat_port_wr_decode #(
  parameter int                        NUM_IDS = 2,
  parameter logic [NUM_IDS-1:0][7:0]   IDS     = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         port_id_i,
  input  logic               io_strb_i,
  output logic [NUM_IDS-1:0] wr_o
);

  logic strb_q;
  logic wr_edge;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) strb_q <= 1'b0;
    else       strb_q <= io_strb_i;

  assign wr_edge = io_strb_i & ~strb_q;

  for (genvar g = 0; g < NUM_IDS; g++) begin : g_id
    assign wr_o[g] = wr_edge & (port_id_i == IDS[g]);
  end

endmodule

// File: rtl/servo_pwm_port.sv
// RAT I/O-bus servo PWM responder: double-buffered position, frame-aligned
// updates, position/status readback and an optional frame-start interrupt.
module servo_pwm_port
  import solar_rat_io_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int PERIOD_US   = 20000,
  parameter int MIN_US      = 1000,
  parameter int MAX_US      = 2000,
  parameter int IRQ_LEN     = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  servo_pwm_port_if.slave         bus,
  output logic                    PWM_OUT,
  output logic                    FRAME_IRQ
);

  localparam int PRE   = CLK_FREQ_HZ / 1_000_000;
  localparam int PRE_W = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int CW    = $clog2(PERIOD_US);
  localparam int DW    = (MAX_US > MIN_US) ? $clog2(MAX_US - MIN_US + 1) : 1;
  localparam int PW    = 8 + DW;
  localparam int IW    = (IRQ_LEN > 0) ? $clog2(IRQ_LEN + 1) : 1;
  localparam logic [PW-1:0] SPAN = PW'(MAX_US - MIN_US);

  logic [1:0]       wr;
  logic             wr_pos, wr_ctrl;
  logic             en_q, en_d, irq_en_q, irq_en_d, pend_q, pend_d;
  logic [7:0]       pos_pend_q, pos_pend_d, pos_act_q, pos_act_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CW-1:0]    cnt_q, cnt_d, width_q, width_d;
  logic [IW-1:0]    irq_q, irq_d;
  logic [PW-1:0]    prod;
  servo_state_t     state_q, state_d;
  logic             pwm_q;
  logic             en_rise, us_tick, wrap, boundary;

  rat_port_wr_decode #(
    .NUM_IDS (2),
    .IDS     ({SERVO_CTRL_ID, SERVO_POS_ID})
  ) u_dec (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .port_id_i (bus.PORT_ID),
    .io_strb_i (bus.IO_STRB),
    .wr_o      (wr)
  );

  assign wr_pos  = wr[0];
  assign wr_ctrl = wr[1];

  assign en_d     = wr_ctrl ? bus.OUT_PORT[0] : en_q;
  assign irq_en_d = wr_ctrl ? bus.OUT_PORT[1] : irq_en_q;
  assign en_rise  = en_d & ~en_q;
  assign us_tick  = en_q && (pre_q == PRE_W'(PRE - 1));
  assign wrap     = us_tick && (cnt_q == CW'(PERIOD_US - 1));
  assign boundary = wrap | en_rise;

  // Counters restart from zero on the enable edge so the first frame is whole.
  always_comb begin
    pre_d = '0;
    cnt_d = '0;
    if (en_q && en_d) begin
      pre_d = us_tick ? '0 : pre_q + PRE_W'(1);
      if (wrap)         cnt_d = '0;
      else if (us_tick) cnt_d = cnt_q + CW'(1);
      else              cnt_d = cnt_q;
    end
  end

  // A write landing on a boundary goes to the pending slot; the boundary
  // still takes the older pending value.
  always_comb begin
    pos_pend_d = pos_pend_q;
    pos_act_d  = pos_act_q;
    pend_d     = pend_q;
    if (boundary && pend_q) begin
      pos_act_d = pos_pend_q;
      pend_d    = 1'b0;
    end
    if (wr_pos) begin
      pos_pend_d = bus.OUT_PORT;
      pend_d     = 1'b1;
    end
  end

  assign prod    = PW'(pos_act_q) * SPAN;
  assign width_d = CW'(MIN_US) + CW'(prod >> 8);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_rise) state_d = PULSE;
      PULSE:   if (cnt_d >= width_q) state_d = GAP;
      GAP:     if (wrap) state_d = PULSE;
      default: state_d = IDLE;
    endcase
    if (!en_d) state_d = IDLE;
  end

  always_comb begin
    irq_d = (irq_q != '0) ? irq_q - IW'(1) : '0;
    if (boundary && en_d && irq_en_d) irq_d = IW'(IRQ_LEN);
  end

  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      pend_q     <= 1'b0;
      pos_pend_q <= '0;
      pos_act_q  <= '0;
      pre_q      <= '0;
      cnt_q      <= '0;
      width_q    <= CW'(MIN_US);
      irq_q      <= '0;
      state_q    <= IDLE;
      pwm_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      pend_q     <= pend_d;
      pos_pend_q <= pos_pend_d;
      pos_act_q  <= pos_act_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      width_q    <= width_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
      pwm_q      <= (state_d == PULSE);
    end

  assign PWM_OUT   = pwm_q;
  assign FRAME_IRQ = (irq_q != '0);

  always_comb begin
    bus.IN_DATA = '0;
    case (bus.PORT_ID)
      SERVO_POS_ID:  bus.IN_DATA = pos_act_q;
      SERVO_STAT_ID: bus.IN_DATA = servo_stat(pend_q, irq_en_q, en_q);
      default:       bus.IN_DATA = '0;
    endcase
  end

endmodule

// File: tb/tb_servo_pwm_port.sv
// Directed bench for servo_pwm_port: PRE=4, 40 us frame (160 CLK), 10..20 us pulse.
module tb_servo_pwm_port;
  import solar_rat_io_pkg::*;

  localparam int FRAME = 160;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic PWM_OUT, FRAME_IRQ;
  int   checks = 0;
  int   errors = 0;

  servo_pwm_port_if bus();

  servo_pwm_port #(
    .CLK_FREQ_HZ (4_000_000),
    .PERIOD_US   (40),
    .MIN_US      (10),
    .MAX_US      (20),
    .IRQ_LEN     (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .PWM_OUT   (PWM_OUT),
    .FRAME_IRQ (FRAME_IRQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] pos;
    int         exp_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic rd(string name, logic [7:0] id, logic [7:0] exp);
    bus.PORT_ID = id;
    #1;
    chk(name, 32'(bus.IN_DATA), 32'(exp));
  endtask

  // Strobe starts n posedges from now and is held for len CLK cycles.
  task automatic wr_at(int n, logic [7:0] id, logic [7:0] d, int len);
    repeat (n) @(posedge CLK);
    #1 bus.PORT_ID = id; bus.OUT_PORT = d; bus.IO_STRB = 1'b1;
    repeat (len) @(posedge CLK);
    #1 bus.IO_STRB = 1'b0;
  endtask

  task automatic wr(logic [7:0] id, logic [7:0] d);
    wr_at(1, id, d, 2);
  endtask

  // Next full frame from a PWM rise; returns at the first cycle of the frame after.
  task automatic measure(output int hi, output int lo, output logic irq_r);
    int n;
    hi = 0; lo = 0; irq_r = 1'b0; n = 0;
    while (PWM_OUT !== 1'b0 && n < 400) begin @(negedge CLK); n++; end
    while (PWM_OUT !== 1'b1 && n < 800) begin @(negedge CLK); n++; end
    if (PWM_OUT !== 1'b1) begin hi = -1; lo = -1; return; end
    irq_r = FRAME_IRQ;
    while (PWM_OUT === 1'b1 && hi < 400) begin hi++; @(negedge CLK); end
    while (PWM_OUT === 1'b0 && lo < 400) begin lo++; @(negedge CLK); end
  endtask

  task automatic count_hi(output int hi);
    hi = 0;
    while (PWM_OUT === 1'b1 && hi < 400) begin
      @(negedge CLK);
      if (PWM_OUT === 1'b1) hi++;
    end
  endtask

  task automatic irq_watch(output int len, output logic pwm_now, output logic pwm_prev);
    int   n;
    logic p;
    n = 0; len = 0; pwm_now = 1'b0; pwm_prev = 1'b0; p = PWM_OUT;
    while (FRAME_IRQ !== 1'b1 && n < 400) begin p = PWM_OUT; @(negedge CLK); n++; end
    if (FRAME_IRQ !== 1'b1) begin len = -1; return; end
    pwm_now = PWM_OUT; pwm_prev = p;
    while (FRAME_IRQ === 1'b1 && len < 100) begin len++; @(negedge CLK); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi, lo, ilen, quiet;
    logic irq, pnow, pprev;

    vecs[0] = '{8'd0,   40};
    vecs[1] = '{8'd64,  48};
    vecs[2] = '{8'd200, 68};
    vecs[3] = '{8'd25,  40};
    vecs[4] = '{8'd26,  44};
    vecs[5] = '{8'd128, 60};

    bus.PORT_ID = 8'h00; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b0;

    // 1: reset, idle, ignored IDs
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_pwm", 32'(PWM_OUT), 0);
    chk("rst_irq", 32'(FRAME_IRQ), 0);
    rd("rst_stat", SERVO_STAT_ID, 8'h00);
    rd("rst_pos", SERVO_POS_ID, 8'h00);
    rd("rd_other_id", LIGHT_ID, 8'h00);
    wr(LEDS_ID, 8'hFF);
    wr(SERVO_STAT_ID, 8'hFF);
    rd("stat_after_foreign_wr", SERVO_STAT_ID, 8'h00);
    rd("pos_after_foreign_wr", SERVO_POS_ID, 8'h00);

    // 2: enable at centre position
    wr(SERVO_POS_ID, 8'd128);
    rd("stat_pend", SERVO_STAT_ID, 8'h04);
    rd("pos_before_en", SERVO_POS_ID, 8'h00);
    wr(SERVO_CTRL_ID, 8'h01);
    rd("stat_en_consumed", SERVO_STAT_ID, 8'h01);
    rd("pos_en", SERVO_POS_ID, 8'd128);
    measure(hi, lo, irq);
    chk("centre_hi", hi, 60);
    chk("centre_lo", lo, 100);
    chk("centre_noirq", 32'(irq), 0);

    // 3: long strobe with data changing after the first cycle -> one write of 255
    @(posedge CLK);
    #1 bus.PORT_ID = SERVO_POS_ID; bus.OUT_PORT = 8'd255; bus.IO_STRB = 1'b1;
    @(posedge CLK);
    #1 bus.OUT_PORT = 8'd7;
    repeat (3) @(posedge CLK);
    #1 bus.IO_STRB = 1'b0;
    rd("stat_long_pend", SERVO_STAT_ID, 8'h05);
    rd("pos_long_old", SERVO_POS_ID, 8'd128);
    measure(hi, lo, irq);
    chk("full_hi", hi, 76);
    chk("full_period", hi + lo, FRAME);
    rd("pos_full", SERVO_POS_ID, 8'd255);
    rd("stat_full_loaded", SERVO_STAT_ID, 8'h01);

    for (int i = 0; i < 6; i++) begin
      wr(SERVO_POS_ID, vecs[i].pos);
      measure(hi, lo, irq);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_period", i), hi + lo, FRAME);
      rd($sformatf("vec%0d_pos", i), SERVO_POS_ID, vecs[i].pos);
    end

    // 4: write 0 on the exact wrap cycle with 200 pending
    measure(hi, lo, irq);
    wr_at(1, SERVO_POS_ID, 8'd200, 2);
    wr_at(156, SERVO_POS_ID, 8'd0, 2);
    count_hi(hi);
    chk("bnd_frame1_hi_rest", hi, 67);
    rd("bnd_stat_pend", SERVO_STAT_ID, 8'h05);
    rd("bnd_pos_200", SERVO_POS_ID, 8'd200);
    measure(hi, lo, irq);
    chk("bnd_frame2_hi", hi, 40);
    chk("bnd_frame2_lo", lo, 120);
    rd("bnd_pos_0", SERVO_POS_ID, 8'd0);
    rd("bnd_stat_clear", SERVO_STAT_ID, 8'h01);

    // 5: frame IRQ on, then off
    wr(SERVO_CTRL_ID, 8'h03);
    rd("irq_stat", SERVO_STAT_ID, 8'h03);
    for (int f = 0; f < 2; f++) begin
      irq_watch(ilen, pnow, pprev);
      chk($sformatf("irq%0d_len", f), ilen, 2);
      chk($sformatf("irq%0d_pwm_rise", f), 32'(pnow), 1);
      chk($sformatf("irq%0d_pwm_prev", f), 32'(pprev), 0);
    end
    wr(SERVO_CTRL_ID, 8'h01);
    quiet = 0;
    repeat (400) begin
      @(negedge CLK);
      if (FRAME_IRQ !== 1'b0) quiet++;
    end
    chk("irq_off_cycles", quiet, 0);

    // 6: disable mid-pulse, re-enable, async reset mid-pulse
    measure(hi, lo, irq);
    @(posedge CLK);
    #1 bus.PORT_ID = SERVO_CTRL_ID; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b1;
    @(negedge CLK);
    chk("dis_pwm_before", 32'(PWM_OUT), 1);
    @(negedge CLK);
    chk("dis_pwm_after", 32'(PWM_OUT), 0);
    @(posedge CLK);
    #1 bus.IO_STRB = 1'b0;
    rd("dis_stat", SERVO_STAT_ID, 8'h00);
    fork
      wr(SERVO_CTRL_ID, 8'h03);
      measure(hi, lo, irq);
    join
    chk("reen_first_hi", hi, 40);
    chk("reen_first_lo", lo, 120);
    chk("reen_irq_at_rise", 32'(irq), 1);
    chk("pre_reset_pwm", 32'(PWM_OUT), 1);
    chk("pre_reset_irq", 32'(FRAME_IRQ), 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_pwm", 32'(PWM_OUT), 0);
    chk("async_rst_irq", 32'(FRAME_IRQ), 0);
    rd("async_rst_stat", SERVO_STAT_ID, 8'h00);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    quiet = 0;
    repeat (200) begin
      @(negedge CLK);
      if (PWM_OUT !== 1'b0) quiet++;
    end
    chk("post_rst_pwm_quiet", quiet, 0);
    rd("post_rst_pos", SERVO_POS_ID, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_port.md
Name: servo_pwm_port

Overview:
RAT I/O-bus responder that consumes MCU port writes and drives a hobby-servo PWM pin from the SolarRAT top level. It decodes PORT_ID/IO_STRB writes for position and control, and double-buffers position so updates take effect only at frame boundaries. It provides readback of position and status on the input-port mux, and can raise a frame-start interrupt usable as MCU INTR.

Parameters:
CLK_FREQ_HZ, 100_000_000, CLK frequency; PRE = CLK_FREQ_HZ/1_000_000 cycles per µs tick
PERIOD_US, 20000, PWM frame length in µs
MIN_US, 1000, pulse width at position 0
MAX_US, 2000, full-scale pulse width reference
IRQ_LEN, 2, FRAME_IRQ pulse length in CLK cycles (covers one 50 MHz MCU cycle)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
PORT_ID  in  8  MCU port address
OUT_PORT  in  8  MCU write data
IO_STRB  in  1  MCU write strobe, high for one MCU cycle (2 CLK cycles)
IN_DATA  out  8  readback data; 0 when PORT_ID is not a read ID of this block
PWM_OUT  out  1  servo pulse, registered
FRAME_IRQ  out  1  frame-start interrupt pulse

Behaviour:
- Reset: asynchronous, active-high. pos_pend=0, pos_act=0, pend=0, EN=0, IRQ_EN=0, counters=0, state=IDLE, PWM_OUT=0, FRAME_IRQ=0. Reset asserted mid-pulse drops PWM_OUT immediately.
- Write detect: a write is accepted on the CLK cycle where IO_STRB is 1 and the registered IO_STRB is 0 (rising edge). Exactly one write per strobe regardless of strobe length.
- Write map:
  - SERVO_POS_ID 0x22: pos_pend<=OUT_PORT, pend<=1.
  - SERVO_CTRL_ID 0x24: EN<=bit0, IRQ_EN<=bit1; other bits ignored.
  - Other IDs: ignored.
- Read map (combinational):
  - SERVO_POS_ID 0x22 -> pos_act.
  - SERVO_STAT_ID 0x23 -> {5'b0, pend, IRQ_EN, EN}.
  - Else 0.
- Timing: the prescaler counts 0..PRE-1 and us_tick fires at PRE-1. The frame counter cnt_us counts 0..PERIOD_US-1 on us_tick and wraps to 0. While EN=0, both counters are held at 0.
- Frame boundary occurs on either:
  - the us_tick where cnt_us=PERIOD_US-1, or
  - the cycle EN goes 0->1.
  At a boundary with pend=1: pos_act<=pos_pend, pend<=0.
- Simultaneous write and boundary: the boundary transfers the old pos_pend. The new value lands in pos_pend and pend stays 1.
- Width: width_us = MIN_US + ((pos_act*(MAX_US-MIN_US))>>8), registered, 1 cycle after pos_act changes. Default range is 1000..1996 µs; pos 128 gives 1500.
- FSM states:
  - IDLE: EN=0.
  - PULSE: cnt_us<width_us.
  - GAP: otherwise.
  Transitions:
  - IDLE->PULSE on EN rise.
  - PULSE->GAP when cnt_us reaches width_us.
  - GAP->PULSE at the wrap.
  - Any state ->IDLE on EN=0, which also forces PWM_OUT low on the next cycle.
- PWM_OUT = (state==PULSE), registered.
- FRAME_IRQ: asserted for IRQ_LEN cycles starting the cycle after each boundary, only when EN=1 and IRQ_EN=1. A new boundary during an active pulse restarts the length count.
- Arithmetic: cnt_us width is $clog2(PERIOD_US). The width product is 8 bits × $clog2(MAX_US-MIN_US+1) bits and is unsigned.

Decomposition:
- Shared package solar_rat_io_pkg holds all port ID constants:
  - SWITCHES 0xFF, LIGHT 0x21, LEDS 0x40, SEG 0x81, SERVO_POS 0x22, SERVO_STAT 0x23, SERVO_CTRL 0x24.
  - typedef servo_state_t {IDLE, PULSE, GAP}.
- One sub-module, rat_port_wr_decode: IO_STRB edge detect plus ID match, emitting one-cycle wr_pos/wr_ctrl strobes. It is reusable by other peripherals.

Test Plan:
Bench parameters: CLK_FREQ_HZ=4_000_000 (PRE=4), PERIOD_US=40, MIN_US=10, MAX_US=20.
1. Reset then idle: RESET pulse, no writes -> PWM_OUT=0, FRAME_IRQ=0, read 0x23 returns 0x00, read 0x22 returns 0x00.
2. Enable and centre: write 0x22=128, then 0x24=0x01 -> pend is consumed at EN rise; PWM high for 15 µs (60 CLK), low for 25 µs (100 CLK); period 160 CLK.
3. Full scale and strobe length: write 0x22=255 with IO_STRB held 4 CLK -> one write only; pend=1 until the next wrap, then pulse is 19 µs (76 CLK); read 0x23 = 0x01 after the load.
4. Write on boundary cycle: write 0x22=0 on the exact wrap cycle while pos_pend=200 -> next frame uses 200 (17 µs), the following frame uses 0 (10 µs); pend reads 1 between the two.
5. IRQ: write 0x24=0x03 -> FRAME_IRQ high for exactly 2 CLK after every boundary; write 0x24=0x01 -> no further IRQ.
6. Disable and reset mid-pulse: write 0x24=0x00 during PULSE -> PWM_OUT low on the next cycle and counters return to 0. Asynchronous RESET mid-pulse -> PWM_OUT low without waiting for a CLK edge.
